hazard_pipe_ctrl: RTL and testbench

Control-path pipeline register chain (ID/EX, EX/MEM, MEM/WB) with load-use hazard detection, stall and flush generation for the 5-stage CPU. It latches the register numbers and write/store/load flags of each instruction as it advances from ID to WB. It produces the EX-, M- and WB-stage fields that the forwarding unit consumes (Ra_EX, Rb_EX, Rd_M, Rb_M, RegWr_M, MemWr_M, Rd_WB, RegWr_WB). It stalls the front end and injects bubbles for hazards that forwarding cannot cover, and squashes wrong-path instructions on a taken branch resolved in EX.

---
 rtl/hazard_pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: ID/EX, EX/MEM and MEM/WB control-path registers with
// load-use stall detection, branch flush generation and a saturating
// stall-cycle counter.
module hazard_pipe_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Ra_ID,
    input  logic [REG_W-1:0] Rb_ID,
    input  logic [REG_W-1:0] Rd_ID,
    input  logic             UsesRb_ID,
    input  logic             RegWr_ID,
    input  logic             MemWr_ID,
    input  logic             MemtoReg_ID,
    input  logic             BrTaken_EX,
    output logic [REG_W-1:0] Ra_EX,
    output logic [REG_W-1:0] Rb_EX,
    output logic [REG_W-1:0] Rd_EX,
    output logic             RegWr_EX,
    output logic             MemtoReg_EX,
    output logic [REG_W-1:0] Rd_M,
    output logic [REG_W-1:0] Rb_M,
    output logic             RegWr_M,
    output logic             MemWr_M,
    output logic             MemtoReg_M,
    output logic [REG_W-1:0] Rd_WB,
    output logic             RegWr_WB,
    output logic             MemtoReg_WB,
    output logic             PcWr,
    output logic             IfIdWr,
    output logic             IfIdFlush,
    output logic [CNT_W-1:0] StallCnt
);

    // ID/EX stage
    logic [REG_W-1:0] ra_ex_q, ra_ex_d, rb_ex_q, rb_ex_d, rd_ex_q, rd_ex_d;
    logic             regwr_ex_q, regwr_ex_d, memwr_ex_q, memwr_ex_d;
    logic             memtoreg_ex_q, memtoreg_ex_d;
    // EX/MEM stage
    logic [REG_W-1:0] rd_m_q, rd_m_d, rb_m_q, rb_m_d;
    logic             regwr_m_q, regwr_m_d, memwr_m_q, memwr_m_d;
    logic             memtoreg_m_q, memtoreg_m_d;
    // MEM/WB stage
    logic [REG_W-1:0] rd_wb_q, rd_wb_d;
    logic             regwr_wb_q, regwr_wb_d, memtoreg_wb_q, memtoreg_wb_d;
    // Stall counter
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic stall;
    logic bubble;

    // Load in EX feeding an ID source; a store whose only dependence is its
    // data operand (Rb) is exempt because the WB->M forward covers it.
    always_comb begin
        load_use = memtoreg_ex_q && regwr_ex_q && (rd_ex_q != '0) &&
                   ((rd_ex_q == Ra_ID) ||
                    (UsesRb_ID && (rd_ex_q == Rb_ID) && !MemWr_ID));
        stall    = load_use && !BrTaken_EX;
        bubble   = load_use || BrTaken_EX;
    end

    // Front-end control: flush beats stall; everything held low in reset.
    always_comb begin
        PcWr      = 1'b0;
        IfIdWr    = 1'b0;
        IfIdFlush = 1'b0;
        if (rst_n) begin
            if (BrTaken_EX) begin
                PcWr      = 1'b1;
                IfIdWr    = 1'b1;
                IfIdFlush = 1'b1;
            end else if (!load_use) begin
                PcWr      = 1'b1;
                IfIdWr    = 1'b1;
            end
        end
    end

    // Next-state for all stages; later stages always advance.
    always_comb begin
        ra_ex_d       = Ra_ID;
        rb_ex_d       = Rb_ID;
        rd_ex_d       = Rd_ID;
        regwr_ex_d    = RegWr_ID;
        memwr_ex_d    = MemWr_ID;
        memtoreg_ex_d = MemtoReg_ID;
        if (bubble) begin
            ra_ex_d       = '0;
            rb_ex_d       = '0;
            rd_ex_d       = '0;
            regwr_ex_d    = 1'b0;
            memwr_ex_d    = 1'b0;
            memtoreg_ex_d = 1'b0;
        end
        rd_m_d        = rd_ex_q;
        rb_m_d        = rb_ex_q;
        regwr_m_d     = regwr_ex_q;
        memwr_m_d     = memwr_ex_q;
        memtoreg_m_d  = memtoreg_ex_q;
        rd_wb_d       = rd_m_q;
        regwr_wb_d    = regwr_m_q;
        memtoreg_wb_d = memtoreg_m_q;
        cnt_d         = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_ex_q       <= '0;
            rb_ex_q       <= '0;
            rd_ex_q       <= '0;
            regwr_ex_q    <= 1'b0;
            memwr_ex_q    <= 1'b0;
            memtoreg_ex_q <= 1'b0;
            rd_m_q        <= '0;
            rb_m_q        <= '0;
            regwr_m_q     <= 1'b0;
            memwr_m_q     <= 1'b0;
            memtoreg_m_q  <= 1'b0;
            rd_wb_q       <= '0;
            regwr_wb_q    <= 1'b0;
            memtoreg_wb_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            ra_ex_q       <= ra_ex_d;
            rb_ex_q       <= rb_ex_d;
            rd_ex_q       <= rd_ex_d;
            regwr_ex_q    <= regwr_ex_d;
            memwr_ex_q    <= memwr_ex_d;
            memtoreg_ex_q <= memtoreg_ex_d;
            rd_m_q        <= rd_m_d;
            rb_m_q        <= rb_m_d;
            regwr_m_q     <= regwr_m_d;
            memwr_m_q     <= memwr_m_d;
            memtoreg_m_q  <= memtoreg_m_d;
            rd_wb_q       <= rd_wb_d;
            regwr_wb_q    <= regwr_wb_d;
            memtoreg_wb_q <= memtoreg_wb_d;
            cnt_q         <= cnt_d;
        end
    end

    assign Ra_EX       = ra_ex_q;
    assign Rb_EX       = rb_ex_q;
    assign Rd_EX       = rd_ex_q;
    assign RegWr_EX    = regwr_ex_q;
    assign MemtoReg_EX = memtoreg_ex_q;
    assign Rd_M        = rd_m_q;
    assign Rb_M        = rb_m_q;
    assign RegWr_M     = regwr_m_q;
    assign MemWr_M     = memwr_m_q;
    assign MemtoReg_M  = memtoreg_m_q;
    assign Rd_WB       = rd_wb_q;
    assign RegWr_WB    = regwr_wb_q;
    assign MemtoReg_WB = memtoreg_wb_q;
    assign StallCnt    = cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Testbench for hazard_pipe_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-level pipeline model.
module tb_hazard_pipe_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SAT   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rd;
        logic             usesrb;
        logic             regwr;
        logic             memwr;
        logic             memtoreg;
    } ins_t;

    logic clk;
    logic rst_n;
    logic br;
    ins_t id;

    logic [REG_W-1:0] Ra_EX, Rb_EX, Rd_EX, Rd_M, Rb_M, Rd_WB;
    logic RegWr_EX, MemtoReg_EX, RegWr_M, MemWr_M, MemtoReg_M;
    logic RegWr_WB, MemtoReg_WB, PcWr, IfIdWr, IfIdFlush;
    logic [CNT_W-1:0] StallCnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // model state: the instruction held in each stage and the stall tally
    ins_t        m_ex, m_m, m_wb;
    int unsigned m_cnt;

    hazard_pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Ra_ID(id.ra), .Rb_ID(id.rb), .Rd_ID(id.rd), .UsesRb_ID(id.usesrb),
        .RegWr_ID(id.regwr), .MemWr_ID(id.memwr), .MemtoReg_ID(id.memtoreg),
        .BrTaken_EX(br),
        .Ra_EX(Ra_EX), .Rb_EX(Rb_EX), .Rd_EX(Rd_EX),
        .RegWr_EX(RegWr_EX), .MemtoReg_EX(MemtoReg_EX),
        .Rd_M(Rd_M), .Rb_M(Rb_M), .RegWr_M(RegWr_M), .MemWr_M(MemWr_M),
        .MemtoReg_M(MemtoReg_M),
        .Rd_WB(Rd_WB), .RegWr_WB(RegWr_WB), .MemtoReg_WB(MemtoReg_WB),
        .PcWr(PcWr), .IfIdWr(IfIdWr), .IfIdFlush(IfIdFlush),
        .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [38:0] obs_regs = {Ra_EX, Rb_EX, Rd_EX, RegWr_EX, MemtoReg_EX,
                            Rd_M, Rb_M, RegWr_M, MemWr_M, MemtoReg_M,
                            Rd_WB, RegWr_WB, MemtoReg_WB, StallCnt};
    wire [2:0]  obs_comb = {PcWr, IfIdWr, IfIdFlush};

    function automatic logic [38:0] exp_regs();
        return {m_ex.ra, m_ex.rb, m_ex.rd, m_ex.regwr, m_ex.memtoreg,
                m_m.rd, m_m.rb, m_m.regwr, m_m.memwr, m_m.memtoreg,
                m_wb.rd, m_wb.regwr, m_wb.memtoreg, CNT_W'(m_cnt)};
    endfunction

    // a load sitting in EX whose result the ID instruction needs before M
    function automatic bit m_loaduse();
        bit src_a, src_b;
        src_a = (m_ex.rd == id.ra);
        src_b = id.usesrb && (m_ex.rd == id.rb) && !id.memwr;
        return m_ex.memtoreg && m_ex.regwr && (m_ex.rd != 0) && (src_a || src_b);
    endfunction

    function automatic logic [2:0] exp_comb();
        if (!rst_n)      return 3'b000;
        if (br)          return 3'b111;
        if (m_loaduse()) return 3'b000;
        return 3'b110;
    endfunction

    function automatic ins_t mk(int ra, int rb, int rd, bit usesrb, bit regwr,
                                bit memwr, bit memtoreg);
        ins_t t;
        t.ra = REG_W'(ra); t.rb = REG_W'(rb); t.rd = REG_W'(rd);
        t.usesrb = usesrb; t.regwr = regwr; t.memwr = memwr; t.memtoreg = memtoreg;
        return t;
    endfunction

    // one clock: model advances with the same inputs the DUT sees at the edge
    task automatic step();
        bit lu, b;
        lu = m_loaduse();
        b  = br;
        @(posedge clk);
        m_wb = m_m;
        m_m  = m_ex;
        m_ex = (lu || b) ? ins_t'('0) : id;
        if (lu && !b && m_cnt < SAT) m_cnt++;
        #1;
    endtask

    task automatic model_clear();
        m_ex = '0; m_m = '0; m_wb = '0; m_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br = 1'b0; id = '0;
        model_clear();
        #1;
        n_checks++;
        if (obs_regs !== 39'd0) $display("FAIL reset_regs got=%h want=0", obs_regs);
        else n_pass++;
        n_checks++;
        if (obs_comb !== 3'b000) $display("FAIL reset_comb got=%b want=000", obs_comb);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        // fill the pipe with loads and dependents so reset hits a busy state
        id = mk(1, 0, 2, 0, 1, 0, 1); step();
        id = mk(2, 1, 5, 1, 1, 0, 0); step();
        id = mk(3, 3, 6, 1, 1, 0, 1); step();
        id = mk(6, 0, 7, 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (obs_regs !== 39'd0) $display("FAIL reset_async_regs got=%h want=0", obs_regs);
        else n_pass++;
        n_checks++;
        if (obs_comb !== 3'b000) $display("FAIL reset_async_comb got=%b want=000", obs_comb);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        id = mk(9, 10, 11, 1, 1, 0, 0);
        step();
        n_checks++;
        if (Rd_EX !== 5'd11 || Ra_EX !== 5'd9 || Rb_EX !== 5'd10 || RegWr_EX !== 1'b1)
            $display("FAIL reset_release_ex got=%0d/%0d/%0d/%b want=9/10/11/1",
                     Ra_EX, Rb_EX, Rd_EX, RegWr_EX);
        else n_pass++;
        n_checks++;
        if (obs_regs !== exp_regs()) $display("FAIL reset_release_regs got=%h want=%h", obs_regs, exp_regs());
        else n_pass++;
    endtask

    task automatic test_alu_chain();
        int rds[3] = '{3, 4, 5};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            id = (i < 3) ? mk(1, 2, rds[i], 1, 1, 0, 0) : ins_t'('0);
            #1;
            n_checks++;
            if (obs_comb !== 3'b110) $display("FAIL alu_comb cyc=%0d got=%b want=110", i, obs_comb);
            else n_pass++;
            step();
            n_checks++;
            if (obs_regs !== exp_regs()) $display("FAIL alu_regs cyc=%0d got=%h want=%h", i, obs_regs, exp_regs());
            else n_pass++;
        end
        n_checks++;
        if (StallCnt !== 2'd0) $display("FAIL alu_stallcnt got=%0d want=0", StallCnt);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        id = mk(1, 0, 2, 0, 1, 0, 1);
        step();
        id = mk(2, 1, 5, 1, 1, 0, 0);
        #1;
        n_checks++;
        if (obs_comb !== 3'b000) $display("FAIL lu_stall_comb got=%b want=000", obs_comb);
        else n_pass++;
        step();
        n_checks++;
        if (RegWr_EX !== 1'b0 || Rd_EX !== 5'd0 || Rd_M !== 5'd2)
            $display("FAIL lu_bubble got=%b/%0d/%0d want=0/0/2", RegWr_EX, Rd_EX, Rd_M);
        else n_pass++;
        #1;
        n_checks++;
        if (obs_comb !== 3'b110) $display("FAIL lu_resume_comb got=%b want=110", obs_comb);
        else n_pass++;
        step();
        n_checks++;
        if (Rd_EX !== 5'd5 || RegWr_EX !== 1'b1 || StallCnt !== 2'd1)
            $display("FAIL lu_add_ex got=%0d/%b/%0d want=5/1/1", Rd_EX, RegWr_EX, StallCnt);
        else n_pass++;
    endtask

    task automatic test_store_exempt();
        do_reset();
        id = mk(1, 0, 2, 0, 1, 0, 1);
        step();
        id = mk(7, 2, 0, 1, 0, 1, 0);
        #1;
        n_checks++;
        if (obs_comb !== 3'b110) $display("FAIL st_nostall_comb got=%b want=110", obs_comb);
        else n_pass++;
        step();
        id = '0;
        step();
        n_checks++;
        if (Rd_WB !== 5'd2 || RegWr_WB !== 1'b1 || Rb_M !== 5'd2 || MemWr_M !== 1'b1 || StallCnt !== 2'd0)
            $display("FAIL st_fwd got=%0d/%b/%0d/%b/%0d want=2/1/2/1/0",
                     Rd_WB, RegWr_WB, Rb_M, MemWr_M, StallCnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        id = mk(1, 0, 2, 0, 1, 0, 1);
        step();
        id = mk(2, 0, 8, 0, 1, 0, 0);
        br = 1'b1;
        #1;
        n_checks++;
        if (obs_comb !== 3'b111) $display("FAIL flush_comb got=%b want=111", obs_comb);
        else n_pass++;
        step();
        br = 1'b0;
        n_checks++;
        if (RegWr_EX !== 1'b0 || Rd_EX !== 5'd0 || Rd_M !== 5'd2 || StallCnt !== 2'd0)
            $display("FAIL flush_state got=%b/%0d/%0d/%0d want=0/0/2/0", RegWr_EX, Rd_EX, Rd_M, StallCnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int want[5] = '{1, 2, 3, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            id = mk(1, 0, 4, 0, 1, 0, 1);
            step();
            id = mk(0, 4, 6, 1, 1, 0, 0);
            step();
            n_checks++;
            if (StallCnt !== 2'(want[i])) $display("FAIL sat_cnt n=%0d got=%0d want=%0d", i, StallCnt, want[i]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            id = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                    1'($urandom_range(0, 1)));
            br = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            #1;
            n_checks++;
            if (obs_comb !== exp_comb()) $display("FAIL rnd_comb cyc=%0d got=%b want=%b", i, obs_comb, exp_comb());
            else n_pass++;
            step();
            n_checks++;
            if (obs_regs !== exp_regs()) $display("FAIL rnd_regs cyc=%0d got=%h want=%h", i, obs_regs, exp_regs());
            else n_pass++;
        end
        br = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_store_exempt();
        test_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
